lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store master that drives the word-addressed data memory port on behalf of the pipeline. Accepts one load or store request at a time over a valid/ready handshake, performs aligned byte, halfword and word accesses, and returns one response per request. The memory port writes whole words only, so sub-word stores use a read-modify-write sequence. Sits between the execute/mem stage and the data memory.

## Interface
- MEM_WORDS, 128, number of 32-bit words in the memory; word index `req_addr[31:2]` >= MEM_WORDS is out of range
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size or out of range; no memory access performed
- mem_address  out  32  memory byte address, word-aligned (bits [1:0] = 0)
- mem_writedata  out  32  memory write word
- mem_memread  out  1  memory read enable
- mem_memwrite  out  1  memory write enable, sampled by memory on rising clk
- mem_readdata  in  32  memory read word, combinational from mem_address while mem_memread = 1

## Operation
- Little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; halfword at addr[1] = bits [16·addr[1]+15 : 16·addr[1]].
- Error checks at acceptance: size 11; half with addr[0] = 1; word with addr[1:0] != 0; word index >= MEM_WORDS. Any failure -> resp_err = 1, no mem_memread/mem_memwrite pulse.
- States:
  - IDLE: req_ready = 1. On req_valid: latch request. Error -> RESP. Otherwise -> ACCESS.
  - ACCESS: mem_address = {addr[31:2], 2'b00}. Loads and sub-word stores: mem_memread = 1, mem_readdata captured at the clock edge. Word store: mem_memwrite = 1, mem_writedata = req_wdata. Sub-word store -> MERGE; all others -> RESP.
  - MERGE: mem_memwrite = 1, mem_writedata = captured word with the addressed lane replaced by the store data; other lanes unchanged. -> RESP.
  - RESP: resp_valid = 1, held stable with resp_rdata/resp_err until resp_ready. On resp_ready -> IDLE.
- Load result: selected lane extended per req_unsigned; word loads pass through unchanged.
- mem_memread and mem_memwrite are never high in the same cycle, and both are 0 in IDLE and RESP.
- A req_valid that arrives while not in IDLE is not accepted; the requester holds it.

## Timing
- Reset (rst_n low at a rising edge): state IDLE; resp_valid 0, resp_rdata 0, resp_err 0, mem_memread 0, mem_memwrite 0, mem_address 0, mem_writedata 0; req_ready = 1 once rst_n is high. Reset mid-access aborts the access: no write occurs on the reset edge or any later edge, and the pending response is dropped.
- Requests are accepted on edge T. Load or word store: ACCESS in T..T+1, resp_valid from T+2. Sub-word store: ACCESS, MERGE, resp_valid from T+3. Error: resp_valid from T+1.
- resp_valid and resp_ready both high at edge E -> IDLE after E, and the next request can be accepted at E+1. There is no same-cycle turnaround.
- Throughput is one request per 3 cycles best case, 4 cycles for sub-word stores.

## Test plan
- Memory model preloaded with word i = i. Load word at address 0x14 -> one memread cycle at 0x14, resp_rdata = 0x00000005, resp_err = 0, resp_valid 2 cycles after acceptance.
- Store word 0xDEADBEEF to 0x08, then load half signed from 0x0A -> resp_rdata 0xFFFFDEAD. Load byte unsigned from 0x08 -> resp_rdata 0x000000EF.
- Store byte 0xAA to 0x11 (word 4 = 0x4) -> read then write cycles. Word 4 becomes 0x0000AA04. resp_valid 3 cycles after acceptance.
- Errors: half load at 0x03, word store at 0x06, size 11, load at 0x200 (index 128) -> resp_err = 1, resp_rdata = 0, no mem enable pulse, resp_valid 1 cycle after acceptance.
- Backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready = 0, a second req_valid is not accepted until the cycle after the handshake.
- Assert rst_n = 0 during MERGE of a byte store -> target word unchanged, all outputs at reset values, and the next request completes normally.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Pipeline-side request/response handshake plus the word-wide data memory port.
// No storage of its own; signals pass straight through between the two modports.
// Requests wait on req_ready and responses wait on resp_ready; the memory port has no backpressure.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_readdata;

    // Load/store unit side
    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_writedata, mem_memread, mem_memwrite
    );

    // Pipeline and memory side
    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_writedata, mem_memread, mem_memwrite
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store master: aligned byte/half/word accesses to a word-only memory, read-modify-write for sub-word stores.
// Latency from acceptance: error 1 cycle, load or word store 2, sub-word store 3.
// One request in flight; req_ready only in IDLE, and the response is held until resp_ready.
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_mem_master_if.master   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        req_err, sub_store;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] merged, load_ext;

    // Legality of the incoming request, evaluated at acceptance only
    always_comb begin
        case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS) req_err = 1'b1;
    end

    assign sub_store = write_q && (size_q != 2'b10);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latch and read-word capture; cleared on reset so a pending response is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                write_q <= bus.req_write;
                uns_q   <= bus.req_unsigned;
                err_q   <= req_err;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == ACCESS && !(write_q && size_q == 2'b10)) word_q <= bus.mem_readdata;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = sub_store ? MERGE : RESP;
            MERGE:   state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
        lane_h = word_q[{addr_q[1], 4'b0000} +: 16];
        merged = word_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = word_q;
        endcase
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = word_q;
        endcase
    end

    // Outputs decoded from state; memory enables are gated by rst_n so a reset edge never writes
    always_comb begin
        bus.req_ready     = (state_q == IDLE);
        bus.resp_valid    = 1'b0;
        bus.resp_rdata    = 32'h0;
        bus.resp_err      = 1'b0;
        bus.mem_address   = 32'h0;
        bus.mem_writedata = 32'h0;
        bus.mem_memread   = 1'b0;
        bus.mem_memwrite  = 1'b0;
        case (state_q)
            ACCESS: begin
                bus.mem_address = {addr_q[31:2], 2'b00};
                if (write_q && size_q == 2'b10) begin
                    bus.mem_memwrite  = rst_n;
                    bus.mem_writedata = wdata_q;
                end else begin
                    bus.mem_memread = rst_n;
                end
            end
            MERGE: begin
                bus.mem_address   = {addr_q[31:2], 2'b00};
                bus.mem_memwrite  = rst_n;
                bus.mem_writedata = merged;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || write_q) ? 32'h0 : load_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
    localparam int MEM_WORDS = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_mem_master_if bus();
    lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    // Environment memory (what the DUT really touches) and the bench's shadow copy
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] exp_mem [MEM_WORDS];

    assign bus.mem_readdata = bus.mem_memread ? mem[bus.mem_address[8:2]] : 32'h0;

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, misalign_cnt = 0;
    logic [31:0] last_addr = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_memwrite) mem[bus.mem_address[8:2]] = bus.mem_writedata;
        if (bus.mem_memread) rd_cnt++;
        if (bus.mem_memwrite) wr_cnt++;
        if (bus.mem_memread && bus.mem_memwrite) both_cnt++;
        if (bus.mem_memread || bus.mem_memwrite) begin
            last_addr = bus.mem_address;
            if (bus.mem_address[1:0] != 2'b00) misalign_cnt++;
        end
    end

    int n_checks = 0, n_fail = 0;
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic un,
                             input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    // One full transaction: model prediction, drive, latency measure, optional backpressure, checks
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic        exp_err;
        logic [31:0] exp_rdata, mask, v, r0;
        int          nbytes, sh, idx, exp_lat, exp_rd, exp_wr, lat, rd0, wr0;
        bit          seen;

        exp_err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
                  || ((a >> 2) >= 32'(MEM_WORDS));
        nbytes  = 1 << int'(sz);
        mask    = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        sh      = 8 * int'(a[1:0]);
        idx     = int'(a[8:2]);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (wr) begin
                exp_mem[idx] = (exp_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
            end else begin
                v = (exp_mem[idx] >> sh) & mask;
                if (!un && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
                exp_rdata = v;
            end
        end
        exp_lat = exp_err ? 1 : ((wr && nbytes < 4) ? 3 : 2);
        exp_rd  = exp_err ? 0 : ((!wr || nbytes < 4) ? 1 : 0);
        exp_wr  = (exp_err || !wr) ? 0 : 1;

        @(negedge clk);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'h1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        drive_req(wr, sz, un, a, wd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        seen = 1'b0;
        lat  = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, ".timeout"}, 32'h0, 32'h1);
            return;
        end

        // Backpressure: response must hold, and a competing request must not be taken
        for (int h = 0; h < hold; h++) begin
            r0 = bus.resp_rdata;
            if (h == 0) drive_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hBAD0_BAD0);
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'h1);
            check({tag, ".hold_rdata"}, bus.resp_rdata, r0);
            check({tag, ".hold_req_ready"}, 32'(bus.req_ready), 32'h0);
        end
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        @(negedge clk);
        check({tag, ".idle_after"}, 32'(bus.req_ready), 32'h1);
        check({tag, ".resp_drop"}, 32'(bus.resp_valid), 32'h0);

        check({tag, ".rdata"}, got_rdata, exp_rdata);
        check({tag, ".err"}, 32'(got_err), 32'(exp_err));
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (!exp_err) check({tag, ".addr"}, last_addr, {a[31:2], 2'b00});
        if (!exp_err && wr) check({tag, ".memword"}, mem[idx], exp_mem[idx]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        wr, un;
        logic [1:0]  sz;
        logic [31:0] a;
        int          wr0;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 32'(i);
            exp_mem[i] = 32'(i);
        end
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.resp_valid", 32'(bus.resp_valid), 32'h0);
        check("reset.resp_rdata", bus.resp_rdata, 32'h0);
        check("reset.resp_err", 32'(bus.resp_err), 32'h0);
        check("reset.memread", 32'(bus.mem_memread), 32'h0);
        check("reset.memwrite", 32'(bus.mem_memwrite), 32'h0);
        check("reset.address", bus.mem_address, 32'h0);
        check("reset.writedata", bus.mem_writedata, 32'h0);
        rst_n = 1'b1;
        #1 check("reset.req_ready", 32'(bus.req_ready), 32'h1);

        do_req("ld_w_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);
        check("ld_w_14.value", got_rdata, 32'h0000_0005);
        do_req("st_w_08", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, 0);
        do_req("ld_hs_0a", 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 0);
        check("ld_hs_0a.value", got_rdata, 32'hFFFF_DEAD);
        do_req("ld_bu_08", 1'b0, 2'b00, 1'b1, 32'h08, 32'h0, 0);
        check("ld_bu_08.value", got_rdata, 32'h0000_00EF);
        do_req("st_b_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA, 0);
        check("st_b_11.word4", mem[4], 32'h0000_AA04);

        do_req("err_half_03", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 0);
        do_req("err_stw_06", 1'b1, 2'b10, 1'b0, 32'h06, 32'h1234_5678, 0);
        do_req("err_size3", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 0);
        do_req("err_range", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0);
        check("err_range.value", 32'(got_err), 32'h1);

        do_req("bp_ld_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5);
        check("bp_ld_14.value", got_rdata, 32'h0000_0005);
        check("bp.word0_untouched", mem[0], exp_mem[0]);

        // Reset during MERGE of a byte store to word 8
        @(negedge clk);
        wr0 = wr_cnt;
        drive_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_0077);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid.access_read", 32'(bus.mem_memread), 32'h1);
        @(negedge clk);
        check("rst_mid.in_merge", 32'(bus.mem_memwrite), 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid.resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_mid.resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mid.resp_err", 32'(bus.resp_err), 32'h0);
        check("rst_mid.memread", 32'(bus.mem_memread), 32'h0);
        check("rst_mid.memwrite", 32'(bus.mem_memwrite), 32'h0);
        check("rst_mid.address", bus.mem_address, 32'h0);
        check("rst_mid.writedata", bus.mem_writedata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid.req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_mid.no_resp", 32'(bus.resp_valid), 32'h0);
        check("rst_mid.no_write", 32'(wr_cnt - wr0), 32'h0);
        check("rst_mid.word8", mem[8], 32'h0000_0008);
        do_req("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
        check("post_rst_ld.value", got_rdata, 32'h0000_0008);

        // Randomised traffic against the shadow model
        for (int n = 0; n < 60; n++) begin
            int r;
            wr = 1'($urandom % 2);
            un = 1'($urandom % 2);
            r  = int'($urandom % 8);
            sz = (r < 7) ? 2'(r % 3) : 2'b11;
            if ($urandom % 10 == 0) a = $urandom;
            else                    a = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
            if (($urandom % 4) != 0 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
            do_req($sformatf("rnd%0d", n), wr, sz, un, a, $urandom, int'($urandom % 3));
        end

        check("never_rd_and_wr", 32'(both_cnt), 32'h0);
        check("addr_aligned", 32'(misalign_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
